// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller: FSM encoding, register map
// addresses, command-byte field positions and STATUS bit positions.
package spi_ctrl_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned FCNT_W = 4;

  localparam logic [BYTE_W-1:0] ID_VALUE_DEF = 8'h59;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_WDATA   = 3'd2;
  localparam logic [2:0] ST_RDATA   = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ID     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd7;

  localparam int unsigned CMD_RD_BIT   = 7;
  localparam int unsigned CMD_RSVD_MSB = 6;
  localparam int unsigned CMD_RSVD_LSB = 3;
  localparam int unsigned CMD_ADDR_MSB = 2;

  localparam int unsigned STAT_BADCMD_BIT = 1;

  // A command is well formed only when its reserved field is all zeros.
  function automatic logic cmd_is_valid(input logic [BYTE_W-1:0] cmd);
    return cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == '0;
  endfunction

endpackage

// File: rtl/spi_ctrl_regfile.sv
// Byte register file for the SPI command controller: ID/STATUS virtual registers,
// six read/write registers, sticky error flags and a combinational read port.
module spi_ctrl_regfile
  import spi_ctrl_pkg::*;
#(
  parameter logic [BYTE_W-1:0] ID_VALUE = ID_VALUE_DEF,
  parameter int unsigned       NREG     = 8
) (
  input  logic                         clk_12MHz,
  input  logic                         i_rst_n,
  input  logic                         wr_req,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [BYTE_W-1:0]            wr_data,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic                         status_clr,
  input  logic                         badcmd_set,
  input  logic                         busy,
  input  logic [FCNT_W-1:0]            frame_cnt,
  output logic [BYTE_W-1:0]            rd_data_c,
  output logic [BYTE_W-1:0]            status_c,
  output logic [BYTE_W*(NREG-2)-1:0]   ctrl_regs,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_done_addr
);

  localparam int unsigned RW_N = NREG - 2;

  logic [RW_N-1:0][BYTE_W-1:0] rw_q;
  logic                        err_ro_q;
  logic                        err_badcmd_q;
  logic                        wr_ok_c;

  assign ctrl_regs = rw_q;

  // ID and STATUS are not storage; writes to them are dropped and flagged.
  always_comb wr_ok_c = wr_req && (wr_addr != ADDR_ID) && (wr_addr != ADDR_STATUS);

  always_comb status_c = {frame_cnt, 1'b0, err_ro_q, err_badcmd_q, busy};

  always_comb begin
    rd_data_c = '0;
    if (rd_addr == ADDR_ID) begin
      rd_data_c = ID_VALUE;
    end else if (rd_addr == ADDR_STATUS) begin
      rd_data_c = status_c;
    end else begin
      for (int i = 0; i < int'(RW_N); i++) begin
        if (rd_addr == ADDR_W'(i + 1)) rd_data_c = rw_q[i];
      end
    end
  end

  always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rw_q         <= '0;
      err_ro_q     <= 1'b0;
      err_badcmd_q <= 1'b0;
      wr_strobe    <= 1'b0;
      wr_done_addr <= '0;
    end else begin
      wr_strobe <= wr_ok_c;
      if (wr_ok_c) wr_done_addr <= wr_addr;
      for (int i = 0; i < int'(RW_N); i++) begin
        if (wr_ok_c && (wr_addr == ADDR_W'(i + 1))) rw_q[i] <= wr_data;
      end
      // Sticky until a STATUS byte is handed to the slave by a read.
      err_ro_q     <= (err_ro_q & ~status_clr) | (wr_req & ~wr_ok_c);
      err_badcmd_q <= (err_badcmd_q & ~status_clr) | badcmd_set;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: frame FSM, address counter and tx byte scheduling.
// Define SPI_CMD_AUTOINC_EN to advance the address after every data byte.
module spi_cmd_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter logic [BYTE_W-1:0] ID_VALUE = ID_VALUE_DEF,
  parameter int unsigned       NREG     = 8
) (
  input  logic                       clk_12MHz,
  input  logic                       i_rst_n,
  input  logic                       i_sel,
  input  logic                       i_rx_valid,
  input  logic [BYTE_W-1:0]          i_rx_byte,
  output logic [BYTE_W-1:0]          o_tx_byte,
  output logic                       o_tx_load,
  output logic [BYTE_W*(NREG-2)-1:0] o_ctrl_regs,
  output logic                       o_wr_strobe,
  output logic [ADDR_W-1:0]          o_wr_addr
);

  logic [2:0]        state_q, state_d;
  logic              sel_q;
  logic              sel_rise_c;
  logic              busy_c;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_step_c, rd_addr_c, cmd_addr_c;
  logic              cmd_seen_q, cmd_seen_d;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              frame_inc_c;
  logic              wr_req_c;
  logic              status_clr_c;
  logic              badcmd_set_c;
  logic              tx_load_d;
  logic [BYTE_W-1:0] tx_byte_d;
  logic [BYTE_W-1:0] rd_data_c;
  logic [BYTE_W-1:0] status_c;

  spi_ctrl_regfile #(
    .ID_VALUE (ID_VALUE),
    .NREG     (NREG)
  ) u_regfile (
    .clk_12MHz    (clk_12MHz),
    .i_rst_n      (i_rst_n),
    .wr_req       (wr_req_c),
    .wr_addr      (addr_q),
    .wr_data      (i_rx_byte),
    .rd_addr      (rd_addr_c),
    .status_clr   (status_clr_c),
    .badcmd_set   (badcmd_set_c),
    .busy         (busy_c),
    .frame_cnt    (frame_cnt_q),
    .rd_data_c    (rd_data_c),
    .status_c     (status_c),
    .ctrl_regs    (o_ctrl_regs),
    .wr_strobe    (o_wr_strobe),
    .wr_done_addr (o_wr_addr)
  );

  // sel_q resets high so a frame left open across reset needs a fresh rise.
  always_comb sel_rise_c = i_sel & ~sel_q;
  always_comb busy_c     = (state_q != ST_IDLE) | sel_rise_c;
  always_comb cmd_addr_c = i_rx_byte[CMD_ADDR_MSB:0];

`ifdef SPI_CMD_AUTOINC_EN
  always_comb addr_step_c = addr_q + ADDR_W'(1);
`else
  always_comb addr_step_c = addr_q;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_seen_d   = cmd_seen_q;
    rd_addr_c    = addr_q;
    wr_req_c     = 1'b0;
    status_clr_c = 1'b0;
    badcmd_set_c = 1'b0;
    frame_inc_c  = 1'b0;
    tx_load_d    = 1'b0;
    tx_byte_d    = o_tx_byte;

    case (state_q)
      ST_IDLE: begin
        if (sel_rise_c) begin
          state_d    = ST_CMD;
          cmd_seen_d = 1'b0;
          tx_load_d  = 1'b1;
          tx_byte_d  = status_c;
        end
      end
      ST_CMD: begin
        if (i_rx_valid) begin
          if (!cmd_is_valid(i_rx_byte)) begin
            state_d      = ST_DISCARD;
            badcmd_set_c = 1'b1;
            tx_load_d    = 1'b1;
            tx_byte_d    = status_c;
            tx_byte_d[STAT_BADCMD_BIT] = 1'b1;
          end else begin
            addr_d     = cmd_addr_c;
            cmd_seen_d = 1'b1;
            if (i_rx_byte[CMD_RD_BIT]) begin
              state_d      = ST_RDATA;
              rd_addr_c    = cmd_addr_c;
              tx_load_d    = 1'b1;
              tx_byte_d    = rd_data_c;
              status_clr_c = (cmd_addr_c == ADDR_STATUS);
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
      end
      ST_WDATA: begin
        if (i_rx_valid) begin
          wr_req_c = 1'b1;
          addr_d   = addr_step_c;
        end
      end
      ST_RDATA: begin
        if (i_rx_valid) begin
          addr_d       = addr_step_c;
          rd_addr_c    = addr_step_c;
          tx_load_d    = 1'b1;
          tx_byte_d    = rd_data_c;
          status_clr_c = (addr_step_c == ADDR_STATUS);
        end
      end
      ST_DISCARD: begin
        if (i_rx_valid) begin
          tx_load_d = 1'b1;
          tx_byte_d = status_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame close wins over the state transition but not over this cycle's byte.
    if ((state_q != ST_IDLE) && !i_sel) begin
      state_d     = ST_IDLE;
      frame_inc_c = cmd_seen_d;
      cmd_seen_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_12MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b1;
      addr_q      <= '0;
      cmd_seen_q  <= 1'b0;
      frame_cnt_q <= '0;
      o_tx_load   <= 1'b0;
      o_tx_byte   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= i_sel;
      addr_q      <= addr_d;
      cmd_seen_q  <= cmd_seen_d;
      frame_cnt_q <= frame_cnt_q + FCNT_W'(frame_inc_c);
      o_tx_load   <= tx_load_d;
      o_tx_byte   <= tx_byte_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed frames plus random frames
// against a register-map level reference model (honours SPI_CMD_AUTOINC_EN).
module tb_spi_cmd_ctrl;

`ifdef SPI_CMD_AUTOINC_EN
  localparam logic [2:0] STEP = 3'd1;
`else
  localparam logic [2:0] STEP = 3'd0;
`endif

  logic        clk_12MHz;
  logic        i_rst_n;
  logic        i_sel;
  logic        i_rx_valid;
  logic [7:0]  i_rx_byte;
  logic [7:0]  o_tx_byte;
  logic        o_tx_load;
  logic [47:0] o_ctrl_regs;
  logic        o_wr_strobe;
  logic [2:0]  o_wr_addr;

  spi_cmd_ctrl dut (
    .clk_12MHz   (clk_12MHz),
    .i_rst_n     (i_rst_n),
    .i_sel       (i_sel),
    .i_rx_valid  (i_rx_valid),
    .i_rx_byte   (i_rx_byte),
    .o_tx_byte   (o_tx_byte),
    .o_tx_load   (o_tx_load),
    .o_ctrl_regs (o_ctrl_regs),
    .o_wr_strobe (o_wr_strobe),
    .o_wr_addr   (o_wr_addr)
  );

  initial begin
    clk_12MHz = 1'b0;
    forever #5 clk_12MHz = ~clk_12MHz;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_regs [8];
  logic       m_err_ro;
  logic       m_err_bad;
  logic [3:0] m_fc;
  logic [7:0] dat [8];

  function automatic logic [7:0] m_status();
    return {m_fc, 1'b0, m_err_ro, m_err_bad, 1'b1};
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h59;
    if (a == 3'd7) return m_status();
    return m_regs[a];
  endfunction

  function automatic logic [47:0] m_ctrl();
    logic [47:0] v;
    for (int i = 1; i <= 6; i++) v[(i-1)*8 +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_err_ro  = 1'b0;
    m_err_bad = 1'b0;
    m_fc      = 4'd0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_12MHz);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit close);
    i_rx_valid = 1'b1;
    i_rx_byte  = b;
    if (close) i_sel = 1'b0;
    tick();
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'($urandom);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tx_byte", 64'(o_tx_byte), 64'(0));
    chk("rst_tx_load", 64'(o_tx_load), 64'(0));
    chk("rst_wr_strobe", 64'(o_wr_strobe), 64'(0));
    chk("rst_wr_addr", 64'(o_wr_addr), 64'(0));
    chk("rst_ctrl_regs", 64'(o_ctrl_regs), 64'(0));
  endtask

  // One complete frame: preload, command, n data bytes, close.
  task automatic run_frame(input logic [7:0] cmd, input int n, input bit close_last);
    logic [2:0] addr;
    bit         ok;
    bit         rd;
    i_sel = 1'b1;
    tick();
    chk("preload_load", 64'(o_tx_load), 64'(1));
    chk("preload_status", 64'(o_tx_byte), 64'(m_status()));
    tick();
    chk("load_single", 64'(o_tx_load), 64'(0));
    gap();
    ok   = (cmd[6:3] == 4'd0);
    rd   = cmd[7];
    addr = cmd[2:0];
    send(cmd, close_last && (n == 0));
    if (!ok) begin
      m_err_bad = 1'b1;
      chk("badcmd_load", 64'(o_tx_load), 64'(1));
      chk("badcmd_status", 64'(o_tx_byte), 64'(m_status()));
    end else if (rd) begin
      chk("rcmd_load", 64'(o_tx_load), 64'(1));
      chk("rcmd_byte", 64'(o_tx_byte), 64'(m_read(addr)));
      if (addr == 3'd7) begin m_err_ro = 1'b0; m_err_bad = 1'b0; end
    end else begin
      chk("wcmd_noload", 64'(o_tx_load), 64'(0));
    end
    chk("cmd_nostrobe", 64'(o_wr_strobe), 64'(0));
    for (int i = 0; i < n; i++) begin
      gap();
      send(dat[i], close_last && (i == n - 1));
      if (!ok) begin
        chk("discard_load", 64'(o_tx_load), 64'(1));
        chk("discard_status", 64'(o_tx_byte), 64'(m_status()));
        chk("discard_nostrobe", 64'(o_wr_strobe), 64'(0));
      end else if (rd) begin
        addr = addr + STEP;
        chk("rdata_load", 64'(o_tx_load), 64'(1));
        chk("rdata_byte", 64'(o_tx_byte), 64'(m_read(addr)));
        chk("rdata_nostrobe", 64'(o_wr_strobe), 64'(0));
        if (addr == 3'd7) begin m_err_ro = 1'b0; m_err_bad = 1'b0; end
      end else begin
        if (addr == 3'd0 || addr == 3'd7) begin
          m_err_ro = 1'b1;
          chk("wr_ro_nostrobe", 64'(o_wr_strobe), 64'(0));
        end else begin
          m_regs[addr] = dat[i];
          chk("wr_strobe", 64'(o_wr_strobe), 64'(1));
          chk("wr_addr", 64'(o_wr_addr), 64'(addr));
        end
        chk("wr_ctrl_regs", 64'(o_ctrl_regs), 64'(m_ctrl()));
        addr = addr + STEP;
      end
    end
    if (!close_last) begin
      gap();
      i_sel = 1'b0;
      tick();
      chk("close_noload", 64'(o_tx_load), 64'(0));
    end
    if (ok) m_fc = m_fc + 4'd1;
    gap();
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_sel      = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_byte  = 8'h00;
    m_reset();
    #1;
    chk_reset_outputs();
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();

    // Write AA,55 from address 2; the next preload shows frame_cnt=1.
    dat[0] = 8'hAA; dat[1] = 8'h55;
    run_frame(8'h02, 2, 1'b0);
    run_frame(8'h82, 2, 1'b0);

    // Read-only write sets err_ro; STATUS reads report then clear it.
    dat[0] = 8'h12;
    run_frame(8'h00, 1, 1'b0);
    run_frame(8'h87, 1, 1'b0);
    run_frame(8'h87, 0, 1'b0);

    // Bad command: discard, no writes, err_badcmd, frame_cnt untouched.
    dat[0] = 8'h33; dat[1] = 8'h44;
    run_frame(8'h48, 2, 1'b0);
    run_frame(8'h87, 0, 1'b0);

    // Read across the top of the map.
    dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00;
    run_frame(8'h86, 3, 1'b0);

    // Byte arriving in the same cycle the frame closes.
    dat[0] = 8'h5A;
    run_frame(8'h04, 1, 1'b1);
    run_frame(8'h84, 0, 1'b1);

    // Frame closed with no command: no count, no error.
    i_sel = 1'b1;
    tick();
    chk("empty_preload", 64'(o_tx_byte), 64'(m_status()));
    tick();
    i_sel = 1'b0;
    tick();
    gap();
    run_frame(8'h87, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [3:0] rsvd;
      logic [7:0] cmd;
      int         n;
      rsvd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cmd  = {1'($urandom), rsvd, 3'($urandom)};
      n    = $urandom_range(0, 4);
      for (int j = 0; j < 8; j++) dat[j] = 8'($urandom);
      run_frame(cmd, n, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of a write frame.
    i_sel = 1'b1;
    tick();
    tick();
    send(8'h01, 1'b0);
    gap();
    send(8'hC3, 1'b0);
    m_regs[1] = 8'hC3;
    chk("pre_areset_ctrl", 64'(o_ctrl_regs), 64'(m_ctrl()));
    #2;
    i_rst_n = 1'b0;
    #1;
    m_reset();
    chk_reset_outputs();
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("no_preload_after_rst", 64'(o_tx_load), 64'(0));
    send(8'h05, 1'b0);
    chk("idle_rx_noload", 64'(o_tx_load), 64'(0));
    chk("idle_rx_nostrobe", 64'(o_wr_strobe), 64'(0));
    chk("idle_rx_ctrl", 64'(o_ctrl_regs), 64'(0));
    i_sel = 1'b0;
    tick();
    gap();
    dat[0] = 8'h9C;
    run_frame(8'h03, 1, 1'b0);
    run_frame(8'h83, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
